// File: rtl/volumen_tx_trama_pkg.sv
// Shared constants and state encodings for the volume frame transmitter.
package volumen_tx_trama_pkg;

  localparam logic [7:0] FRAME_HDR     = 8'hA5;
  localparam int         FRAME_BYTES   = 4;
  localparam int         BITS_PER_BYTE = 8;

  // Bit-level states of the byte serialiser.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } t_bit_state;

  // Frame-level sequencing states of the top level.
  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_SEND,
    SEQ_DONE
  } t_seq_state;

  // Checksum byte of a frame: XOR of the two volume bytes.
  function automatic logic [7:0] frame_chk(input logic [7:0] hi, input logic [7:0] lo);
    return hi ^ lo;
  endfunction

endpackage

// File: rtl/volumen_tx_trama_uart_tx_byte.sv
// One 8N1 byte serialiser with its own baud counter. oReady is high while
// idle and in the last cycle of a stop bit, so a byte loaded then starts on
// the very next cycle and consecutive bytes leave with no idle gap.
module uart_tx_byte
  import volumen_tx_trama_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iLoad,
  input  logic [7:0] ivByte,
  output logic       oTx,
  output logic       oReady
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(BITS_PER_BYTE - 1);

  t_bit_state    r_state;
  logic [CW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic w_bit_end;

  assign w_bit_end = (r_baud_cnt == BAUD_LAST);
  assign oReady    = (r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end);
  assign oTx       = r_tx;

  // Serialiser: start bit, 8 data bits LSB first, stop bit, each DIV cycles long.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else if (iLoad && oReady) begin
      r_state    <= ST_START;
      r_shift    <= ivByte;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_tx       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
        end
        ST_START: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_state    <= ST_DATA;
            r_tx       <= r_shift[0];
          end else begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt <= '0;
              r_state   <= ST_STOP;
              r_tx      <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_state    <= ST_IDLE;
            r_tx       <= 1'b1;
          end else begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/volumen_tx_trama.sv
// Volume frame transmitter: on iStart snapshots the 14-bit volume and sends
// the 4-byte frame HDR, HI, LO, CHK over a UART line.
module volumen_tx_trama
  import volumen_tx_trama_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iStart,
  input  logic [13:0] ivVolumen,
  output logic        oTx,
  output logic        oBusy,
  output logic        oDone
);

  localparam int         DIV      = CLK_FREQ / BAUD;
  localparam logic [1:0] IDX_LAST = 2'(FRAME_BYTES - 1);

  t_seq_state r_state;
  logic [1:0] r_idx;
  logic [7:0] r_hi;
  logic [7:0] r_lo;
  logic       r_busy;
  logic       r_done;

  logic [1:0] w_next_idx;
  logic [7:0] w_byte;
  logic       w_load;
  logic       w_ready;

  assign oBusy = r_busy;
  assign oDone = r_done;

  // The header is a constant, so the first byte can be loaded in the same
  // cycle the volume snapshot is taken.
  assign w_next_idx = (r_state == SEQ_IDLE) ? 2'd0 : r_idx + 2'd1;

  assign w_load = ((r_state == SEQ_IDLE) && iStart) ||
                  ((r_state == SEQ_SEND) && w_ready && (r_idx != IDX_LAST));

  // Frame-byte mux selected by the index of the byte about to be loaded.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_byte = FRAME_HDR;
    case (w_next_idx)
      2'd0:    w_byte = FRAME_HDR;
      2'd1:    w_byte = r_hi;
      2'd2:    w_byte = r_lo;
      default: w_byte = frame_chk(r_hi, r_lo);
    endcase
  end

  // Frame sequencer: snapshot, byte stepping, and the one-cycle done pulse.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state <= SEQ_IDLE;
      r_idx   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        SEQ_IDLE: begin
          r_done <= 1'b0;
          if (iStart) begin
            r_hi    <= {2'b00, ivVolumen[13:8]};
            r_lo    <= ivVolumen[7:0];
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= SEQ_SEND;
          end
        end
        SEQ_SEND: begin
          if (w_ready) begin
            if (r_idx == IDX_LAST) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= SEQ_DONE;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        SEQ_DONE: begin
          r_done  <= 1'b0;
          r_state <= SEQ_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= SEQ_IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .DIV (DIV)
  ) u_uart_tx_byte (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .iLoad    (w_load),
    .ivByte   (w_byte),
    .oTx      (oTx),
    .oReady   (w_ready)
  );

endmodule

// File: tb/tb_volumen_tx_trama.sv
// Directed bench for volumen_tx_trama with a UART decoder and an
// expected-byte scoreboard. DIV = 16; oTx sampled mid-bit on falling edges.
module tb_volumen_tx_trama;

  localparam int DIV = 16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] vol;
  logic        tx;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int busy_cnt = 0;
  int done_cnt = 0;
  bit mon_abort = 1'b0;

  logic [7:0] exp_q[$];

  volumen_tx_trama #(
    .CLK_FREQ (16),
    .BAUD     (1)
  ) dut (
    .iClk      (clk),
    .iReset_n  (rst_n),
    .iStart    (start),
    .ivVolumen (vol),
    .oTx       (tx),
    .oBusy     (busy),
    .oDone     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Busy-cycle and done-pulse counters.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  end

  // UART decoder: pops the scoreboard for every completed byte.
  initial begin : monitor
    logic [7:0] rx;
    logic       stop_bit;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (DIV) @(negedge clk);
          rx[b] = tx;
        end
        repeat (DIV) @(negedge clk);
        stop_bit = tx;
        if (mon_abort) begin
          mon_abort = 1'b0;
        end else if (exp_q.size() == 0) begin
          check("extra_byte", 32'(rx), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("rx_byte", 32'(rx), 32'(e));
          check("stop_bit", 32'(stop_bit), 32'd1);
        end
      end
    end
  end

  // Called at a falling edge: pulses iStart for one cycle, queues the frame,
  // then checks the first-cycle response.
  task automatic send_frame(input logic [13:0] v);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = {2'b00, v[13:8]};
    lo = v[7:0];
    vol   = v;
    start = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(hi);
    exp_q.push_back(lo);
    exp_q.push_back(hi ^ lo);
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    check("start_bit_now", 32'(tx), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin : main
    bit went_low;
    rst_n = 1'b0;
    start = 1'b0;
    vol   = '0;

    // 1. Reset state and idle line.
    repeat (4) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    went_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) went_low = 1'b1;
    end
    check("idle_tx_high", 32'(went_low), 32'd0);

    // 2. Nominal frame.
    busy_cnt = 0;
    done_cnt = 0;
    send_frame(14'h1234);
    wait_done(800);
    repeat (20) @(negedge clk);
    check("busy_cycles", 32'(busy_cnt), 32'd640);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("q_empty_nominal", 32'(exp_q.size()), 32'd0);

    // 3. Boundary volumes.
    send_frame(14'h0000);
    wait_done(800);
    repeat (20) @(negedge clk);
    check("q_empty_zero", 32'(exp_q.size()), 32'd0);
    send_frame(14'h3FFF);
    wait_done(800);
    repeat (20) @(negedge clk);
    check("q_empty_max", 32'(exp_q.size()), 32'd0);

    // 4. iStart and volume changes while busy are ignored.
    busy_cnt = 0;
    done_cnt = 0;
    send_frame(14'h1234);
    repeat (98) @(negedge clk);
    vol   = 14'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(800);
    repeat (700) @(negedge clk);
    check("busy_reject_done", 32'(done_cnt), 32'd1);
    check("busy_reject_cycles", 32'(busy_cnt), 32'd640);
    check("q_empty_reject", 32'(exp_q.size()), 32'd0);

    // 5. Reset during a data bit of byte 2 aborts the frame.
    done_cnt = 0;
    send_frame(14'h0ABC);
    repeat (350) @(negedge clk);
    mon_abort = 1'b1;
    rst_n     = 1'b0;
    #1;
    check("abort_tx_high", 32'(tx), 32'd1);
    check("abort_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_line_idle", 32'(tx), 32'd1);
    exp_q.delete();
    send_frame(14'h0ABC);
    wait_done(800);
    repeat (20) @(negedge clk);
    check("q_empty_after_abort", 32'(exp_q.size()), 32'd0);

    // 6. Back-to-back frames: second iStart on the cycle after oDone.
    busy_cnt = 0;
    done_cnt = 0;
    send_frame(14'h2A5C);
    wait_done(800);
    @(negedge clk);
    send_frame(14'h15C3);
    wait_done(800);
    repeat (20) @(negedge clk);
    check("b2b_done_pulses", 32'(done_cnt), 32'd2);
    check("b2b_busy_cycles", 32'(busy_cnt), 32'd1280);
    check("q_empty_b2b", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
